// File: rtl/test_harness_monitor.sv
// test_harness_monitor: simulation-side run monitor for the processor tops.
// Watches the PC and the data-store port, detects the pass/fail signature
// store, runs a cycle watchdog and a PC-stall detector, and keeps a circular
// trace of stores for the bench to drain after the run.
// Optional feature macro: HARNESS_TRACE_EN builds the trace buffer; without it
// the trace outputs are tied to zero and trace_rd_en is ignored.
module test_harness_monitor #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                TRACE_DEPTH = 8,
  parameter logic [ADDR_W-1:0] PASS_ADDR   = 'h64,
  parameter logic [DATA_W-1:0] PASS_DATA   = 7,
  parameter int                TIMEOUT     = 1000,
  parameter int                STALL_LIMIT = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_W-1:0]              PC,
  input  logic                           MemWrite,
  input  logic [ADDR_W-1:0]              DataAdr,
  input  logic [DATA_W-1:0]              WriteData,
  input  logic                           trace_rd_en,
  output logic                           trace_rd_valid,
  output logic [ADDR_W+DATA_W-1:0]       trace_rd_data,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  output logic                           trace_overflow,
  output logic                           done,
  output logic                           pass,
  output logic [1:0]                     fail_code,
  output logic [31:0]                    cycle_count
);

  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_DATA  = 2'd1;
  localparam logic [1:0] FC_TIME  = 2'd2;
  localparam logic [1:0] FC_STALL = 2'd3;

  state_e            state_q, state_d;
  logic [1:0]        fail_code_q, fail_code_d;
  logic [31:0]       cycle_cnt_q, cycle_cnt_d;
  logic              done_q, pass_q;
  logic [ADDR_W-1:0] prev_pc_q;
  logic [SW-1:0]     stall_cnt_q, stall_cnt_d;

  logic in_run, sig_wr, pc_same, stall_hit, timeout_hit;

  assign in_run      = (state_q == ST_RUN);
  assign sig_wr      = MemWrite && (DataAdr == PASS_ADDR);
  assign pc_same     = (PC == prev_pc_q);
  // The current cycle is the STALL_LIMIT-th consecutive repeat.
  assign stall_hit   = pc_same && (stall_cnt_q >= SW'(STALL_LIMIT - 1));
  assign timeout_hit = (cycle_cnt_q == 32'(TIMEOUT - 1));

  // Stall counter: consecutive repeats of PC, saturating at the limit.
  always_comb begin
    stall_cnt_d = '0;
    if (pc_same)
      stall_cnt_d = (stall_cnt_q == SW'(STALL_LIMIT)) ? stall_cnt_q
                                                      : stall_cnt_q + SW'(1);
  end

  // Run FSM: signature beats stall beats timeout; terminal states hold.
  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    cycle_cnt_d = cycle_cnt_q;
    if (in_run) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (sig_wr) begin
        if (WriteData == PASS_DATA) begin
          state_d = ST_PASS;
        end else begin
          state_d     = ST_FAIL;
          fail_code_d = FC_DATA;
        end
      end else if (stall_hit) begin
        state_d     = ST_FAIL;
        fail_code_d = FC_STALL;
      end else if (timeout_hit) begin
        state_d     = ST_FAIL;
        fail_code_d = FC_TIME;
      end
    end
  end

  // Control registers; done/pass are flopped from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      fail_code_q <= FC_NONE;
      cycle_cnt_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      prev_pc_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
      cycle_cnt_q <= cycle_cnt_d;
      done_q      <= (state_d != ST_RUN);
      pass_q      <= (state_d == ST_PASS);
      prev_pc_q   <= PC;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_code   = fail_code_q;
  assign cycle_count = cycle_cnt_q;

`ifdef HARNESS_TRACE_EN
  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + DATA_W;

  logic [EW-1:0] mem_q [TRACE_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, rv_q, rv_d;
  logic [EW-1:0] rd_q, rd_d;
  logic          push, pop, full;

  assign push = MemWrite && in_run;
  assign pop  = trace_rd_en && (cnt_q != '0);
  assign full = (cnt_q == CW'(TRACE_DEPTH));

  // Trace pointers/count; a push into a full buffer without a pop
  // drops the oldest entry by advancing the read pointer too.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    rv_d     = 1'b0;
    rd_d     = rd_q;
    if (pop) begin
      rd_d     = mem_q[rd_ptr_q];
      rv_d     = 1'b1;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (full && !pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        ovf_d    = 1'b1;
      end
    end
    if (push && !pop && !full) cnt_d = cnt_q + CW'(1);
    else if (pop && !push)     cnt_d = cnt_q - CW'(1);
  end

  // Trace storage and pointer registers, all cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TRACE_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      rv_q     <= 1'b0;
      rd_q     <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= {DataAdr, WriteData};
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      rv_q     <= rv_d;
      rd_q     <= rd_d;
    end
  end

  assign trace_rd_valid = rv_q;
  assign trace_rd_data  = rd_q;
  assign trace_count    = cnt_q;
  assign trace_overflow = ovf_q;
`else
  logic unused_trace_rd_en;
  assign unused_trace_rd_en = trace_rd_en;

  assign trace_rd_valid = 1'b0;
  assign trace_rd_data  = '0;
  assign trace_count    = '0;
  assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_test_harness_monitor.sv
// Directed bench for test_harness_monitor: a vector table for the pass/drain
// run, then hand sequences for wrong signature, timeout, stall, overflow and
// mid-run reset. Trace expectations collapse to zero when the trace is not built.
module tb_test_harness_monitor;

`ifdef HARNESS_TRACE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic        clk, reset;
  logic [31:0] PC, DataAdr, WriteData;
  logic        MemWrite, trace_rd_en;
  logic        trace_rd_valid, trace_overflow, done, pass;
  logic [63:0] trace_rd_data;
  logic [3:0]  trace_count;
  logic [1:0]  fail_code;
  logic [31:0] cycle_count;
  bit          hold_pc;
  int          n_chk, n_err;

  test_harness_monitor #(
    .ADDR_W(32), .DATA_W(32), .TRACE_DEPTH(8), .PASS_ADDR(32'h64),
    .PASS_DATA(32'd7), .TIMEOUT(50), .STALL_LIMIT(16)
  ) dut (
    .clk(clk), .reset(reset), .PC(PC), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .trace_rd_en(trace_rd_en),
    .trace_rd_valid(trace_rd_valid), .trace_rd_data(trace_rd_data),
    .trace_count(trace_count), .trace_overflow(trace_overflow),
    .done(done), .pass(pass), .fail_code(fail_code), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        rd;
    int          n;
    logic        e_done;
    logic        e_pass;
    logic [1:0]  e_fc;
    logic [31:0] e_cc;
    logic [3:0]  e_cnt;
    logic        e_rv;
    logic [63:0] e_rd;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic d, input logic p,
                        input logic [1:0] fc, input logic [31:0] cc);
    chk({tag, ".done"}, 64'(done), 64'(d));
    chk({tag, ".pass"}, 64'(pass), 64'(p));
    chk({tag, ".fail_code"}, 64'(fail_code), 64'(fc));
    chk({tag, ".cycle_count"}, 64'(cycle_count), 64'(cc));
  endtask

  task automatic chk_tr(input string tag, input logic [3:0] cnt, input logic ovf,
                        input logic rv, input logic [63:0] rd);
    chk({tag, ".trace_count"}, 64'(trace_count), TR ? 64'(cnt) : 64'd0);
    chk({tag, ".trace_overflow"}, 64'(trace_overflow), TR ? 64'(ovf) : 64'd0);
    chk({tag, ".trace_rd_valid"}, 64'(trace_rd_valid), TR ? 64'(rv) : 64'd0);
    chk({tag, ".trace_rd_data"}, trace_rd_data, TR ? rd : 64'd0);
  endtask

  function automatic logic [63:0] ent(input int i);
    ent = {32'h200 + 32'(4 * i), 32'(i)};
  endfunction

  task automatic step(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                      input logic rd);
    MemWrite = mw; DataAdr = adr; WriteData = wd; trace_rd_en = rd;
    if (!hold_pc) PC = PC + 32'd4;
    @(posedge clk); #2;
    MemWrite = 1'b0; trace_rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0; MemWrite = 1'b0; trace_rd_en = 1'b0; DataAdr = '0; WriteData = '0;
    hold_pc = 1'b0; PC = 32'h100;
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    //          mw  adr     wd     rd  n   done pass fc  cc   cnt rv  rd
    tbl[0]  = '{0, 32'h0,  32'h0,  0, 5,  0, 0, 2'd0, 5,  4'd0, 0, 64'h0};
    tbl[1]  = '{1, 32'h10, 32'hA1, 0, 1,  0, 0, 2'd0, 6,  4'd1, 0, 64'h0};
    tbl[2]  = '{0, 32'h0,  32'h0,  0, 4,  0, 0, 2'd0, 10, 4'd1, 0, 64'h0};
    tbl[3]  = '{1, 32'h20, 32'hB2, 0, 1,  0, 0, 2'd0, 11, 4'd2, 0, 64'h0};
    tbl[4]  = '{0, 32'h0,  32'h0,  0, 19, 0, 0, 2'd0, 30, 4'd2, 0, 64'h0};
    tbl[5]  = '{1, 32'h64, 32'h7,  0, 1,  1, 1, 2'd0, 31, 4'd3, 0, 64'h0};
    tbl[6]  = '{0, 32'h0,  32'h0,  0, 3,  1, 1, 2'd0, 31, 4'd3, 0, 64'h0};
    tbl[7]  = '{0, 32'h0,  32'h0,  1, 1,  1, 1, 2'd0, 31, 4'd2, 1, 64'h00000010_000000A1};
    tbl[8]  = '{0, 32'h0,  32'h0,  0, 1,  1, 1, 2'd0, 31, 4'd2, 0, 64'h00000010_000000A1};
    tbl[9]  = '{0, 32'h0,  32'h0,  1, 1,  1, 1, 2'd0, 31, 4'd1, 1, 64'h00000020_000000B2};
    tbl[10] = '{0, 32'h0,  32'h0,  1, 1,  1, 1, 2'd0, 31, 4'd0, 1, 64'h00000064_00000007};
    tbl[11] = '{0, 32'h0,  32'h0,  1, 1,  1, 1, 2'd0, 31, 4'd0, 0, 64'h00000064_00000007};
    tbl[12] = '{1, 32'h30, 32'h5,  0, 1,  1, 1, 2'd0, 31, 4'd0, 0, 64'h00000064_00000007};

    // Reset state, then the pass run with drain.
    do_reset();
    chk_st("reset", 0, 0, 2'd0, 0);
    chk_tr("reset", 0, 0, 0, 64'h0);
    for (int i = 0; i < 13; i++) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].mw, tbl[i].adr, tbl[i].wd, tbl[i].rd);
      chk_st($sformatf("v%0d", i), tbl[i].e_done, tbl[i].e_pass, tbl[i].e_fc, tbl[i].e_cc);
      chk_tr($sformatf("v%0d", i), tbl[i].e_cnt, 1'b0, tbl[i].e_rv, tbl[i].e_rd);
    end

    // Wrong signature data, then a correct one that must be ignored.
    do_reset();
    idle(3);
    step(1'b1, 32'h64, 32'd5, 1'b0);
    chk_st("badsig", 1, 0, 2'd1, 4);
    chk_tr("badsig", 1, 0, 0, 64'h0);
    step(1'b1, 32'h64, 32'd7, 1'b0);
    chk_st("badsig_late", 1, 0, 2'd1, 4);
    chk_tr("badsig_late", 1, 0, 0, 64'h0);

    // Watchdog.
    do_reset();
    idle(49);
    chk_st("tmo_49", 0, 0, 2'd0, 49);
    idle(1);
    chk_st("tmo_50", 1, 0, 2'd2, 50);
    idle(3);
    chk_st("tmo_frozen", 1, 0, 2'd2, 50);

    // Stall coinciding with signature: signature wins.
    do_reset();
    PC = 32'h8; hold_pc = 1'b1;
    idle(16);
    chk_st("stallsig_pre", 0, 0, 2'd0, 16);
    step(1'b1, 32'h64, 32'd7, 1'b0);
    chk_st("stallsig", 1, 1, 2'd0, 17);

    // Pure stall: first repeat in cycle 1, failure on the 16th repeat.
    do_reset();
    PC = 32'h8; hold_pc = 1'b1;
    idle(16);
    chk_st("stall_pre", 0, 0, 2'd0, 16);
    idle(1);
    chk_st("stall", 1, 0, 2'd3, 17);

    // Fill, push+pop while full, then overflow.
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 32'h200 + 32'(4 * i), 32'(i), 1'b0);
    chk_tr("full", 8, 0, 0, 64'h0);
    step(1'b1, 32'h200 + 32'd36, 32'd9, 1'b1);
    chk_tr("full_pushpop", 8, 0, 1, ent(1));
    step(1'b1, 32'h200 + 32'd40, 32'd10, 1'b0);
    chk_tr("overflow", 8, 1, 0, ent(1));
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk_tr("ovf_pop3", 7, 1, 1, ent(3));
    for (int j = 4; j <= 10; j++) begin
      step(1'b0, 32'h0, 32'h0, 1'b1);
      chk_tr($sformatf("drain%0d", j), 4'(10 - j), 1, 1, ent(j));
    end
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk_tr("pop_empty", 0, 1, 0, ent(10));
    chk_st("ovf_run", 0, 0, 2'd0, 19);

    // Mid-run reset after four stores clears everything at once.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'h300 + 32'(4 * i), 32'(i), 1'b0);
    chk_tr("pre_rst", 4, 1, 0, ent(10));
    reset = 1'b0;
    #1;
    chk_st("midrst", 0, 0, 2'd0, 0);
    chk_tr("midrst", 0, 0, 0, 64'h0);
    @(posedge clk); #2;
    reset = 1'b1;
    idle(3);
    chk_st("restart", 0, 0, 2'd0, 3);
    chk_tr("restart", 0, 0, 0, 64'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    chk_tr("restart_pop", 0, 0, 0, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
